// File: rtl/dir_seq_player.sv
// Plays a stored 3-bit direction sequence onto a valid/ready bus, once per start pulse.
// Sequence lives in a reloadable 8x3 register file; optional idle gap after each symbol.
module dir_seq_player #(
  parameter int SEQ_LEN = 5,
  parameter int GAP     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_en,
  input  logic [2:0] load_addr,
  input  logic [2:0] load_data,
  input  logic       start,
  input  logic       abort,
  output logic [2:0] dir_out,
  output logic       dir_valid,
  input  logic       dir_ready,
  output logic [2:0] idx_out,
  output logic       busy,
  output logic       play_done
);

  typedef enum logic [1:0] {IDLE, EMIT, GAPW, DONE} state_t;

  localparam logic [2:0] LAST     = 3'(SEQ_LEN - 1);
  localparam logic [3:0] LEN      = 4'(SEQ_LEN);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : '0;

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_gap_cnt;
  logic [2:0] r_mem [8];

  logic w_wr;

  assign w_wr = load_en && (r_state == IDLE) && ({1'b0, load_addr} < LEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) r_mem[i] <= '0;
      r_mem[1] <= 3'b011;
      r_mem[2] <= 3'b001;
      r_mem[3] <= 3'b010;
    end else if (w_wr) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // abort outranks everything, including a transfer on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_gap_cnt <= '0;
    end else if (abort) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= EMIT;
            r_idx   <= '0;
          end
        end
        EMIT: begin
          if (dir_ready) begin
            if (r_idx == LAST) begin
              r_state <= DONE;
              r_idx   <= '0;
            end else if (GAP == 0) begin
              r_idx <= r_idx + 3'd1;
            end else begin
              r_state   <= GAPW;
              r_idx     <= r_idx + 3'd1;
              r_gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAPW: begin
          if (r_gap_cnt == '0) r_state <= EMIT;
          else                 r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dir_valid = (r_state == EMIT);
  assign busy      = (r_state != IDLE);
  assign play_done = (r_state == DONE);
  assign idx_out   = r_idx;
  assign dir_out   = dir_valid ? r_mem[r_idx] : '0;

endmodule

// File: tb/tb_dir_seq_player.sv
// Directed bench for dir_seq_player: one GAP=0 instance and one GAP=2 instance on shared inputs.
module tb_dir_seq_player;

  logic       clk = 1'b0;
  logic       reset, load_en, start, abort, dir_ready;
  logic [2:0] load_addr, load_data;

  logic [2:0] d0, i0, d2, i2;
  logic       v0, b0, p0, v2, b2, p2;

  logic       sel;
  logic [2:0] wd, wi;
  logic       wv, wb, wp;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] exp_seq [5];
  logic [2:0] got [$];

  always #5 clk = ~clk;

  dir_seq_player #(.SEQ_LEN(5), .GAP(0)) u0 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .abort(abort), .dir_out(d0),
    .dir_valid(v0), .dir_ready(dir_ready), .idx_out(i0), .busy(b0), .play_done(p0)
  );

  dir_seq_player #(.SEQ_LEN(5), .GAP(2)) u2 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .abort(abort), .dir_out(d2),
    .dir_valid(v2), .dir_ready(dir_ready), .idx_out(i2), .busy(b2), .play_done(p2)
  );

  always_comb begin
    wd = sel ? d2 : d0;
    wi = sel ? i2 : i0;
    wv = sel ? v2 : v0;
    wb = sel ? b2 : b0;
    wp = sel ? p2 : p0;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a playback from IDLE and score it against exp_seq.
  task automatic play(input int stall_at, input int stall_n, input int restart_at,
                      input int busy_wr_at, input int exp_done, input int exp_gaps);
    int first_v, done_cyc, busy_fall, n_done, gaps, stall_left;
    got.delete();
    first_v = -1; done_cyc = -1; busy_fall = -1; n_done = 0; gaps = 0;
    stall_left = stall_n;
    dir_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    load_en = 1'b0;
    for (int c = 1; c < 100; c++) begin
      if (done_cyc >= 0 && !wb) begin
        busy_fall = c;
        break;
      end
      start = (c == restart_at);
      load_en = (c == busy_wr_at);
      if (c == busy_wr_at) begin
        load_addr = 3'd3;
        load_data = 3'b111;
      end
      if (wv) begin
        if (first_v < 0) first_v = c;
        if (got.size() == stall_at && stall_left > 0) begin
          dir_ready = 1'b0;
          chk("stall_dir", int'(wd), int'(exp_seq[stall_at]));
          chk("stall_idx", int'(wi), stall_at);
          stall_left--;
        end else begin
          dir_ready = 1'b1;
          chk("idx", int'(wi), got.size());
          got.push_back(wd);
        end
      end else if (first_v >= 0 && wb && !wp) begin
        gaps++;
      end
      if (wp) begin
        done_cyc = c;
        n_done++;
      end
      step();
    end
    start = 1'b0;
    load_en = 1'b0;
    dir_ready = 1'b1;
    chk("len", got.size(), 5);
    for (int k = 0; k < 5; k++) chk("sym", int'(got[k]), int'(exp_seq[k]));
    chk("first_valid", first_v, 1);
    chk("done_cycle", done_cyc, exp_done);
    chk("busy_fall", busy_fall, exp_done + 1);
    chk("done_pulses", n_done, 1);
    chk("gap_cycles", gaps, exp_gaps);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int found, pulses;
    sel = 1'b0;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; abort = 1'b0; dir_ready = 1'b1;
    #1;
    chk("rst_dir", int'(d0), 0);
    chk("rst_valid", int'(v0), 0);
    chk("rst_idx", int'(i0), 0);
    chk("rst_busy", int'(b0), 0);
    chk("rst_done", int'(p0), 0);
    step(); step();
    reset = 1'b0;
    step();

    // default playback, then back-to-back restart with a 3-cycle stall at symbol 2
    exp_seq = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b000};
    play(-1, 0, -1, -1, 6, 0);
    play(2, 3, -1, -1, 9, 0);

    // start while busy must not restart
    play(-1, 0, 2, -1, 6, 0);

    // load entry 1, attempt out-of-range entry 6, then a write while busy
    load_en = 1'b1; load_addr = 3'd1; load_data = 3'b111;
    step();
    load_addr = 3'd6; load_data = 3'b101;
    step();
    load_en = 1'b0;
    exp_seq = '{3'b000, 3'b111, 3'b001, 3'b010, 3'b000};
    play(-1, 0, -1, 2, 6, 0);
    play(-1, 0, -1, -1, 6, 0);

    // load and start in the same IDLE cycle
    load_en = 1'b1; load_addr = 3'd0; load_data = 3'b101;
    exp_seq = '{3'b101, 3'b111, 3'b001, 3'b010, 3'b000};
    play(-1, 0, -1, -1, 6, 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", int'(b0), 0);
    chk("sa_valid", int'(v0), 0);
    step();
    chk("sa_busy2", int'(b0), 0);

    // abort in the cycle symbol 3 is accepted
    start = 1'b1; dir_ready = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (v0 && i0 == 3'd3) begin
        found = 1;
        break;
      end
      step();
    end
    chk("abort_reach", found, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", int'(v0), 0);
    chk("abort_busy", int'(b0), 0);
    chk("abort_idx", int'(i0), 0);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (p0) pulses++;
      step();
    end
    chk("abort_no_done", pulses, 0);
    play(-1, 0, -1, -1, 6, 0);

    // asynchronous reset mid-symbol restores outputs and default contents
    start = 1'b1;
    step();
    start = 1'b0; dir_ready = 1'b0;
    step();
    chk("pre_rst_valid", int'(v0), 1);
    #2 reset = 1'b1;
    #1;
    chk("mrst_dir", int'(d0), 0);
    chk("mrst_valid", int'(v0), 0);
    chk("mrst_idx", int'(i0), 0);
    chk("mrst_busy", int'(b0), 0);
    chk("mrst_done", int'(p0), 0);
    reset = 1'b0;
    dir_ready = 1'b1;
    step();
    exp_seq = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b000};
    play(-1, 0, -1, -1, 6, 0);

    // GAP=2 instance from a clean reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    sel = 1'b1;
    #1;
    play(-1, 0, -1, -1, 14, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
